// File: rtl/exp_align.sv
// exp_align: two-stage pre-alignment exponent unit for the FMA datapath.
// Stage 1 forms the product exponent; stage 2 compares it with the addend
// exponent and registers base exponent, alignment shift and path selects.
// Both stages use a valid/ready handshake; every output except in_ready is registered.
module exp_align #(
    parameter int BIAS      = 127,
    parameter int SHIFT_MAX = 26,
    parameter int NEAR_TH   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] exp_a,
    input  logic [7:0] exp_b,
    input  logic [7:0] exp_c,
    input  logic       op_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] base_exp,
    output logic [4:0] align_shift,
    output logic       swap_sel,
    output logic       path_sel,
    output logic       prod_zero,
    output logic       ovf,
    output logic       unf
);

    // Stage 1 state
    logic              s1_valid;
    logic signed [9:0] s1_exp_p;
    logic [7:0]        s1_exp_c;
    logic              s1_op_sel;
    logic              s1_prod_zero;

    // Handshake enables
    logic s1_en;
    logic s2_en;

    // Stage 1 combinational product exponent (-127..383 fits in 10-bit signed)
    logic [9:0] exp_p_next;

    // Stage 2 combinational results
    logic signed [10:0] d;
    logic [10:0]        abs_d;
    logic               ovf_next;
    logic               unf_next;
    logic [7:0]         base_next;
    logic [4:0]         shift_next;
    logic               swap_next;
    logic               path_next;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    assign exp_p_next = {2'b00, exp_a} + {2'b00, exp_b} - 10'(BIAS);

    // Stage 1 register: capture product exponent and addend on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            s1_valid     <= 1'b0;
            s1_exp_p     <= '0;
            s1_exp_c     <= '0;
            s1_op_sel    <= 1'b0;
            s1_prod_zero <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_exp_p     <= $signed(exp_p_next);
                s1_exp_c     <= exp_c;
                s1_op_sel    <= op_sel;
                s1_prod_zero <= (exp_a == 8'd0) || (exp_b == 8'd0);
            end
        end
    end

    // Stage 2 compare: exponent difference, saturation, swap and path selects
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the branches can leave a latch behind.
        d          = {s1_exp_p[9], s1_exp_p} - $signed({3'b000, s1_exp_c});
        abs_d      = d[10] ? 11'(-d) : 11'(d);
        ovf_next   = !s1_prod_zero && (s1_exp_p > 10'sd254);
        unf_next   = !s1_prod_zero && (s1_exp_p < 10'sd1);
        base_next  = s1_exp_c;
        shift_next = 5'd0;
        swap_next  = 1'b1;
        path_next  = s1_op_sel && !s1_prod_zero && (abs_d <= 11'(NEAR_TH));

        if (!s1_prod_zero) begin
            shift_next = (abs_d > 11'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : abs_d[4:0];
            if (!d[10]) begin
                swap_next = 1'b0;
                if (ovf_next)
                    base_next = 8'hff;
                else if (unf_next)
                    base_next = 8'h00;
                else
                    base_next = s1_exp_p[7:0];
            end
        end
    end

    // Stage 2 register: outputs advance only when the consumer can take them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data outputs are reset too, so nothing stale is
            // visible on the port while out_valid is low after reset.
            out_valid   <= 1'b0;
            base_exp    <= '0;
            align_shift <= '0;
            swap_sel    <= 1'b0;
            path_sel    <= 1'b0;
            prod_zero   <= 1'b0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                base_exp    <= base_next;
                align_shift <= shift_next;
                swap_sel    <= swap_next;
                path_sel    <= path_next;
                prod_zero   <= s1_prod_zero;
                ovf         <= ovf_next;
                unf         <= unf_next;
            end
        end
    end

endmodule

// File: tb/tb_exp_align.sv
// tb_exp_align: scoreboard bench for exp_align. The driver pushes the
// reference result for every accepted operand; an independent monitor pops
// and compares whenever a result is handed over, and tracks pipeline
// occupancy to check in_ready, out_valid and stall stability.
module tb_exp_align;

    typedef struct packed {
        logic [7:0] base;
        logic [4:0] shift;
        logic       swap;
        logic       path;
        logic       pz;
        logic       ovf;
        logic       unf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] exp_a = '0;
    logic [7:0] exp_b = '0;
    logic [7:0] exp_c = '0;
    logic       op_sel = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] base_exp;
    logic [4:0] align_shift;
    logic       swap_sel;
    logic       path_sel;
    logic       prod_zero;
    logic       ovf;
    logic       unf;

    int n_vec  = 0;
    int n_fail = 0;

    res_t exp_q[$];

    // out_ready modes: 0 = high, 1 = low, 2 = fixed pattern, 3 = random
    int   rdy_mode = 0;
    int   pat_i    = 0;
    logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    exp_align #(.BIAS(127), .SHIFT_MAX(26), .NEAR_TH(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .exp_c      (exp_c),
        .op_sel     (op_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .base_exp   (base_exp),
        .align_shift(align_shift),
        .swap_sel   (swap_sel),
        .path_sel   (path_sel),
        .prod_zero  (prod_zero),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic straight from the exponent rules
    function automatic res_t model(input int a, input int b, input int c, input int op);
        res_t r;
        int   p, d, ad;
        bit   pz;
        p  = a + b - 127;
        pz = (a == 0) || (b == 0);
        d  = p - c;
        ad = (d < 0) ? -d : d;
        r.pz   = pz;
        r.ovf  = !pz && (p > 254);
        r.unf  = !pz && (p < 1);
        r.path = (op != 0) && !pz && (ad <= 1);
        if (pz) begin
            r.base = 8'(c); r.shift = 5'd0; r.swap = 1'b1;
        end else if (d >= 0) begin
            if (p > 254)    r.base = 8'd255;
            else if (p < 1) r.base = 8'd0;
            else            r.base = 8'(p);
            r.swap  = 1'b0;
            r.shift = 5'((ad > 26) ? 26 : ad);
        end else begin
            r.base  = 8'(c);
            r.swap  = 1'b1;
            r.shift = 5'((ad > 26) ? 26 : ad);
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        return {base_exp, align_shift, swap_sel, path_sel, prod_zero, ovf, unf};
    endfunction

    // out_ready driver, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                2: begin
                    out_ready = (pat_i < 8) ? pat[pat_i] : 1'b1;
                    pat_i++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: occupancy-based flow checks plus scoreboard compare
    int   in_flight = 0;
    bit   last_acc  = 0;
    bit   stalled   = 0;
    res_t held;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_flight = 0;
            last_acc  = 0;
            stalled   = 0;
        end else begin
            bit   acc, pop;
            res_t want;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            check("in_ready", 32'(in_ready), 32'(!(in_flight == 2 && !out_ready)));
            check("out_valid", 32'(out_valid),
                  32'((in_flight >= 2) || (in_flight == 1 && !last_acc)));
            if (stalled)
                check("stall_hold", 32'(dut_res()), 32'(held));
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(1), 32'(0));
                end else begin
                    want = exp_q.pop_front();
                    check("result", 32'(dut_res()), 32'(want));
                end
            end
            stalled   = out_valid && !out_ready;
            held      = dut_res();
            in_flight = in_flight + int'(acc) - int'(pop);
            last_acc  = acc;
        end
    end

    // Present one operand from posedge+1 until it is accepted
    task automatic send(input int a, input int b, input int c, input int op);
        int tries = 0;
        in_valid = 1'b1;
        exp_a = 8'(a); exp_b = 8'(b); exp_c = 8'(c); op_sel = 1'(op);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, c, op));
                break;
            end
            tries++;
            if (tries > 200) begin
                check("accept_timeout", 32'(0), 32'(1));
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'(0));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_data", 32'(dut_res()), 32'(0));
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operands
        send(130, 127, 128, 0);
        send(100, 100, 200, 0);
        send(128, 127, 127, 1);
        send(200, 200, 100, 0);
        send(10, 10, 50, 1);
        send(0, 150, 90, 1);
        send(127, 127, 126, 1);
        send(127, 127, 0, 0);
        drain();

        // Backpressure pattern over a back-to-back stream of 8
        pat_i = 0; rdy_mode = 2;
        for (int i = 0; i < 8; i++)
            send(120 + i, 127, 118 + 2 * i, i % 2);
        drain();

        // Randomized stimulus under random backpressure
        rdy_mode = 3;
        for (int i = 0; i < 300; i++) begin
            int a, b, c, p;
            a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            p = a + b - 127;
            if ($urandom_range(0, 1) == 1) begin
                c = p + int'($urandom_range(0, 4)) - 2;
                c = (c < 0) ? 0 : ((c > 255) ? 255 : c);
            end else begin
                c = int'($urandom_range(0, 255));
            end
            send(a, b, c, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();

        // Reset mid-operation with both stages full
        rdy_mode = 1;
        @(posedge clk); #1;
        send(140, 130, 100, 0);
        send(90, 90, 60, 1);
        #1;
        check("full_in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(1));
        check("arst_data", 32'(dut_res()), 32'(0));
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;
        send(135, 127, 140, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
